// File: rtl/vga_apb_master.sv
// rtl/vga_apb_master.sv - single-outstanding request/response to APB3 initiator for the VGA CSR slave (optional timeout: VGA_APB_TIMEOUT_EN)
module vga_apb_master #(
    parameter int ADDR_WIDTH     = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // The wait counter is 8 bits wide, so the limit must fit in 1..255.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("vga_apb_master: TIMEOUT_CYCLES must be in 1..255");
    end

    state_t                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

`ifdef VGA_APB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    logic [7:0]            wait_q, wait_d;
`endif

    // Only request acceptance is combinational; everything else comes from flops.
    assign req_ready = (state_q == ST_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Next-state and registered-output computation for the transfer sequencer.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef VGA_APB_TIMEOUT_EN
        wait_d      = wait_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    pwrite_d = req_write;
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef VGA_APB_TIMEOUT_EN
                wait_d    = 8'd0;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end
`ifdef VGA_APB_TIMEOUT_EN
                // A late pready on the limit cycle still wins (checked above).
                else if (wait_q == TIMEOUT_LIMIT) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer in flight.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef VGA_APB_TIMEOUT_EN
    // ACCESS-phase wait counter.
    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            wait_q <= 8'd0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

endmodule

// File: doc/vga_apb_master.md
# vga_apb_master

APB initiator that converts a simple single-outstanding request/response interface into APB3 transfers toward the VGA CSR slave (char X/Y window and color registers). It sits between the host-side command source (test sequencer or control FSM) and the CSR APB port. It issues one transfer at a time, waits on `pready`, and returns read data and error status.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: APB address width.
- `DATA_WIDTH`, default 32: APB data width.
- `TIMEOUT_CYCLES`, default 16: maximum ACCESS-phase wait cycles. Only used when `VGA_APB_TIMEOUT_EN` is defined; legal range 1–255.

Ports:
- `pclk`, in, 1: clock. One clock domain; reset is synchronous and active-low.
- `preset_n`, in, 1: synchronous active-low reset.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted when high together with `req_valid`.
- `req_write`, in, 1: 1 selects write, 0 selects read.
- `req_addr`, in, ADDR_WIDTH: target address.
- `req_wdata`, in, DATA_WIDTH: write data.
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rsp_rdata`, out, DATA_WIDTH: read data, valid with `rsp_valid`.
- `rsp_err`, out, 1: error flag, valid with `rsp_valid`.
- `psel`, out, 1: APB select.
- `penable`, out, 1: APB enable.
- `pwrite`, out, 1: APB direction.
- `paddr`, out, ADDR_WIDTH: APB address.
- `pwdata`, out, DATA_WIDTH: APB write data.
- `prdata`, in, DATA_WIDTH: APB read data.
- `pready`, in, 1: APB ready.
- `pslverr`, in, 1: APB slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered except `req_ready`.
- IDLE:
  - `req_ready = 1`.
  - On `req_valid`, latch `req_write`, `req_addr` and `req_wdata` into `pwrite`, `paddr` and `pwdata`, then go to SETUP.
- SETUP: `psel = 1`, `penable = 0`. Unconditionally go to ACCESS.
- ACCESS: `psel = 1`, `penable = 1`.
  - On `pready = 1`: capture `rsp_rdata = pwrite ? 0 : prdata` and `rsp_err = pslverr`, drop `psel` and `penable`, go to RESP.
  - On `pready = 0`: stay in ACCESS.
- RESP: `rsp_valid = 1` for exactly this cycle. Go to IDLE.
- `req_ready = 0` in SETUP, ACCESS and RESP. Requests presented then are not accepted and must be held by the source.
- `paddr`, `pwrite` and `pwdata` are stable from SETUP through the end of ACCESS. They hold their last value in IDLE and RESP.
- `rsp_rdata` and `rsp_err` hold their values until the next completion.
- Reset values: state IDLE. `psel`, `penable`, `pwrite`, `rsp_valid` and `rsp_err` are 0. `paddr`, `pwdata` and `rsp_rdata` are all zeros. `req_ready` is 1 after reset.
- Reset mid-transfer (`preset_n` low at any posedge): abort immediately and load reset values. No `rsp_valid` is produced for the aborted transfer.

## Timing
- Accept in cycle N (IDLE). SETUP is N+1, ACCESS starts N+2, and RESP (`rsp_valid`) is N+3 when `pready` is high in the first ACCESS cycle.
- Each cycle of `pready = 0` in ACCESS adds one cycle of latency.
- Back-to-back throughput is 1 transfer per 4 cycles: the next acceptance can occur at N+4.
- `psel` is never high for two consecutive transfers without an intervening low cycle.

## Configuration
- The macro `VGA_APB_TIMEOUT_EN` controls an ACCESS-phase timeout.
- When defined:
  - An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready = 0`.
  - When the counter reaches `TIMEOUT_CYCLES` while `pready = 0`, the transfer is abandoned: drop `psel` and `penable`, set `rsp_rdata = 0` and `rsp_err = 1`, go to RESP.
  - `pready = 1` in the same cycle as the limit wins, and the transfer completes normally.
- When undefined: no counter is present, ACCESS waits indefinitely, and `rsp_err` reflects `pslverr` only.

## Test plan
- Write, addr 0x000, wdata 0x0001_4032, `pready` tied 1.
  - `psel` rises at N+1 and `penable` at N+2.
  - `pwdata` = 0x0001_4032 throughout SETUP and ACCESS.
  - `rsp_valid` at N+3 with `rsp_err = 0`.
- Read, addr 0x008, slave `prdata = 0x0000_000A`.
  - `pwrite = 0`.
  - At `rsp_valid`, `rsp_rdata = 0x0000_000A` and `rsp_err = 0`.
- Read with `pready` low for the first 3 ACCESS cycles: ACCESS lasts 4 cycles and `rsp_valid` is at N+6.
- Write with `pslverr = 1` alongside `pready`: `rsp_err = 1` and `rsp_rdata = 0`.
- `req_valid` held high with 3 queued writes: acceptances at cycles N, N+4 and N+8, and `req_ready` is low in between.
- Reset mid-transfer: `preset_n` low during ACCESS.
  - All outputs return to reset values on the next edge and no `rsp_valid` follows.
  - With `VGA_APB_TIMEOUT_EN` and `TIMEOUT_CYCLES = 16`, `pready` held 0 gives `rsp_err = 1` with `rsp_valid` at N+19.
